// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the FPU barrel shifter: shift direction encoding and
// the shift-amount width helper.
package fpu_shift_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    function automatic int unsigned shw_for(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fpu_shift_stage.sv
// One mux level of the logarithmic shifter: shifts by DIST when enabled,
// filling vacated MSBs on a right shift with the supplied fill bit.
module fpu_shift_stage
    import fpu_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> DIST);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            if (i_dir == SHIFT_LEFT) begin
                o_data = i_data << DIST;
            end else begin
                o_data = (i_data >> DIST) | (FILL_MASK & {WIDTH{i_fill}});
            end
        end
    end

endmodule

// File: rtl/fpu_barrel_shifter.sv
// Logarithmic barrel shifter for mantissa alignment/normalisation, with an
// optional register after every second mux level (and after the last level).
module fpu_barrel_shifter
    import fpu_shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SHW       = shw_for(WIDTH),
    parameter bit          PIPELINED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift_amount,
    input  logic             shift_direction,
    input  logic             arithmetic,
    output logic [WIDTH-1:0] data_out
);

    // Sign fill is resolved once at the input so later stages never look at the MSB.
    logic w_sign;
    assign w_sign = arithmetic & (shift_direction == SHIFT_RIGHT) & data_in[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int unsigned AW  = SHW - k;
        localparam bit          REG = PIPELINED && ((k % 2 == 1) || (k == SHW - 1));

        logic [WIDTH-1:0] w_din;
        logic [WIDTH-1:0] w_shifted;
        logic [WIDTH-1:0] w_dout;
        logic [AW-1:0]    w_amt;
        logic             w_dir;
        logic             w_fill;

        if (k == 0) begin : g_src
            assign w_din  = data_in;
            assign w_amt  = shift_amount;
            assign w_dir  = shift_direction;
            assign w_fill = w_sign;
        end else begin : g_src
            assign w_din  = g_lvl[k-1].w_dout;
            assign w_amt  = g_lvl[k-1].g_fwd.w_amt_nxt;
            assign w_dir  = g_lvl[k-1].g_fwd.w_dir_nxt;
            assign w_fill = g_lvl[k-1].g_fwd.w_fill_nxt;
        end

        fpu_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .i_data (w_din),
            .i_en   (w_amt[0]),
            .i_dir  (w_dir),
            .i_fill (w_fill),
            .o_data (w_shifted)
        );

        if (REG) begin : g_reg
            logic [WIDTH-1:0] r_data;
            always_ff @(posedge clk) begin
                if (reset) r_data <= '0;
                else       r_data <= w_shifted;
            end
            assign w_dout = r_data;
        end else begin : g_pass
            assign w_dout = w_shifted;
        end

        // Only the not-yet-consumed amount bits travel on to the next level.
        if (k < SHW - 1) begin : g_fwd
            logic [AW-2:0] w_amt_nxt;
            logic          w_dir_nxt;
            logic          w_fill_nxt;

            if (REG) begin : g_reg
                logic [AW-2:0] r_amt;
                logic          r_dir;
                logic          r_fill;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_amt  <= '0;
                        r_dir  <= 1'b0;
                        r_fill <= 1'b0;
                    end else begin
                        r_amt  <= w_amt[AW-1:1];
                        r_dir  <= w_dir;
                        r_fill <= w_fill;
                    end
                end
                assign w_amt_nxt  = r_amt;
                assign w_dir_nxt  = r_dir;
                assign w_fill_nxt = r_fill;
            end else begin : g_pass
                assign w_amt_nxt  = w_amt[AW-1:1];
                assign w_dir_nxt  = w_dir;
                assign w_fill_nxt = w_fill;
            end
        end
    end

    if (!PIPELINED) begin : g_comb
        logic w_unused_clk;
        assign w_unused_clk = clk ^ reset;
    end

    assign data_out = g_lvl[SHW-1].w_dout;

endmodule

// File: tb/tb_fpu_barrel_shifter.sv
// Self-checking bench: four shifter variants (64/80 bits, comb/pipelined)
// compared every cycle against a plain-arithmetic shift model.
module tb_fpu_barrel_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] d64;
    logic [5:0]  a64;
    logic        dir64, ar64;
    logic [79:0] d80;
    logic [6:0]  a80;
    logic        dir80, ar80;
    logic [63:0] q64c, q64p;
    logic [79:0] q80c, q80p;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 1'b0;

    logic [79:0] pipe64 [3];
    logic [79:0] pipe80 [4];

    typedef struct {
        logic [79:0] d;
        int unsigned a;
        bit          dr;
        bit          ar;
        bit          w80;
        logic [79:0] e;
    } vec_t;
    vec_t vecs [17];

    always #5 clk = ~clk;

    fpu_barrel_shifter #(.WIDTH(64), .PIPELINED(1'b0)) u_c64 (
        .clk(clk), .reset(reset), .data_in(d64), .shift_amount(a64),
        .shift_direction(dir64), .arithmetic(ar64), .data_out(q64c));
    fpu_barrel_shifter #(.WIDTH(64), .PIPELINED(1'b1)) u_p64 (
        .clk(clk), .reset(reset), .data_in(d64), .shift_amount(a64),
        .shift_direction(dir64), .arithmetic(ar64), .data_out(q64p));
    fpu_barrel_shifter #(.WIDTH(80), .PIPELINED(1'b0)) u_c80 (
        .clk(clk), .reset(reset), .data_in(d80), .shift_amount(a80),
        .shift_direction(dir80), .arithmetic(ar80), .data_out(q80c));
    fpu_barrel_shifter #(.WIDTH(80), .PIPELINED(1'b1)) u_p80 (
        .clk(clk), .reset(reset), .data_in(d80), .shift_amount(a80),
        .shift_direction(dir80), .arithmetic(ar80), .data_out(q80p));

    // Reference: whole-word shift of a w-bit value held in 80 bits.
    function automatic logic [79:0] model(input logic [79:0] d, input int unsigned a,
                                          input bit dr, input bit ar, input int unsigned w);
        logic [79:0] m, x, r, fillm;
        m = (w == 80) ? {80{1'b1}} : {16'h0, {64{1'b1}}};
        x = d & m;
        if (!dr) begin
            r = (a >= w) ? '0 : ((x << a) & m);
        end else begin
            r     = (a >= w) ? '0 : (x >> a);
            fillm = (a >= w) ? m : (m & ~(m >> a));
            if (ar && x[w-1]) r = r | fillm;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        if (v.w80) begin
            d80 = v.d; a80 = 7'(v.a); dir80 = v.dr; ar80 = v.ar;
        end else begin
            d64 = v.d[63:0]; a64 = 6'(v.a); dir64 = v.dr; ar64 = v.ar;
        end
    endtask

    // Latency model: result enters a delay line of L slots; reset empties it.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) pipe64[i] <= '0;
            for (int i = 0; i < 4; i++) pipe80[i] <= '0;
        end else begin
            pipe64[0] <= model({16'h0, d64}, a64, dir64, ar64, 64);
            for (int i = 1; i < 3; i++) pipe64[i] <= pipe64[i-1];
            pipe80[0] <= model(d80, a80, dir80, ar80, 80);
            for (int i = 1; i < 4; i++) pipe80[i] <= pipe80[i-1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("comb64", {16'h0, q64c}, model({16'h0, d64}, a64, dir64, ar64, 64));
            check("pipe64", {16'h0, q64p}, pipe64[2]);
            check("comb80", q80c, model(d80, a80, dir80, ar80, 80));
            check("pipe80", q80p, pipe80[3]);
        end
    end

    initial begin
        vecs[0]  = '{80'hA5A5A5A5A5A5A5A5, 0, 1'b0, 1'b0, 1'b0, 80'hA5A5A5A5A5A5A5A5};
        vecs[1]  = '{80'hA5A5A5A5A5A5A5A5, 0, 1'b1, 1'b0, 1'b0, 80'hA5A5A5A5A5A5A5A5};
        vecs[2]  = '{80'hA5A5A5A5A5A5A5A5, 0, 1'b1, 1'b1, 1'b0, 80'hA5A5A5A5A5A5A5A5};
        vecs[3]  = '{80'h0000000000000001, 1, 1'b0, 1'b0, 1'b0, 80'h0000000000000002};
        vecs[4]  = '{80'h00000000000000FF, 8, 1'b0, 1'b0, 1'b0, 80'h000000000000FF00};
        vecs[5]  = '{80'h00000000DEADBEEF, 32, 1'b0, 1'b0, 1'b0, 80'hDEADBEEF00000000};
        vecs[6]  = '{80'h0000000000000001, 63, 1'b0, 1'b0, 1'b0, 80'h8000000000000000};
        vecs[7]  = '{80'h8000000000000000, 1, 1'b1, 1'b0, 1'b0, 80'h4000000000000000};
        vecs[8]  = '{80'hFF00000000000000, 8, 1'b1, 1'b0, 1'b0, 80'h00FF000000000000};
        vecs[9]  = '{80'h4000000000000000, 1, 1'b1, 1'b1, 1'b0, 80'h2000000000000000};
        vecs[10] = '{80'h8000000000000000, 1, 1'b1, 1'b1, 1'b0, 80'hC000000000000000};
        vecs[11] = '{80'hFF00000000000000, 8, 1'b1, 1'b1, 1'b0, 80'hFFFF000000000000};
        vecs[12] = '{80'h0000000000000000FFFF, 16, 1'b0, 1'b0, 1'b1, 80'h000000000000FFFF0000};
        vecs[13] = '{80'hF0000000000000000000, 4, 1'b1, 1'b1, 1'b1, 80'hFF000000000000000000};
        vecs[14] = '{80'h80000000000000000000, 100, 1'b1, 1'b1, 1'b1, {80{1'b1}}};
        vecs[15] = '{80'h80000000000000000000, 100, 1'b1, 1'b0, 1'b1, 80'h0};
        vecs[16] = '{80'h8000000000000001, 4, 1'b0, 1'b1, 1'b0, 80'h0000000000000010};

        reset = 1'b1;
        d64 = '0; a64 = '0; dir64 = 1'b0; ar64 = 1'b0;
        d80 = '0; a80 = '0; dir80 = 1'b0; ar80 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_p64", {16'h0, q64p}, 80'h0);
        check("reset_p80", q80p, 80'h0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors: DUT and model both pinned to hand-computed results.
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("dir%0d_dut", i), vecs[i].w80 ? q80c : {16'h0, q64c}, vecs[i].e);
            check($sformatf("dir%0d_model", i),
                  model(vecs[i].d, vecs[i].a, vecs[i].dr, vecs[i].ar, vecs[i].w80 ? 80 : 64),
                  vecs[i].e);
        end

        // Back-to-back stream into the 64-bit pipeline; each result 3 cycles later.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (i < 12) apply(vecs[i]);
            @(negedge clk);
            if (i >= 3) check($sformatf("stream%0d", i - 3), {16'h0, q64p}, vecs[i-3].e);
        end

        // Reset mid-stream: output clears next cycle and in-flight results vanish.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            apply(vecs[i + 2]);
            reset = (i == 5);
            @(negedge clk);
            if (i >= 6 && i <= 8) check($sformatf("flush%0d", i), {16'h0, q64p}, 80'h0);
            if (i == 9) check("post_reset_first", {16'h0, q64p}, vecs[8].e);
        end

        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            d64   = {$urandom, $urandom};
            a64   = 6'($urandom);
            dir64 = 1'($urandom);
            ar64  = 1'($urandom);
            d80   = {16'($urandom), $urandom, $urandom};
            a80   = 7'($urandom_range(0, 127));
            dir80 = 1'($urandom);
            ar80  = 1'($urandom);
            reset = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
